// File: rtl/alu_pkg.sv
// Shared opcode and FSM state constants for the registered ALU.
// Imported by the top level and the testbench.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

endpackage

// File: rtl/registered_alu_if.sv
// Request/result bus of the registered ALU.
// master: a, b, F, cin, in_valid, out_ready out; ready, valid, result, flags in.
interface registered_alu_if #(
    parameter int WIDTH = 8
);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       F;
    logic             cin;
    logic             in_valid;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] z;
    logic [WIDTH-1:0] z_hi;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             neg;

    modport master (
        output a, b, F, cin, in_valid, out_ready,
        input  in_ready, out_valid, z, z_hi, cout, ovf, zero, neg
    );

    modport slave (
        input  a, b, F, cin, in_valid, out_ready,
        output in_ready, out_valid, z, z_hi, cout, ovf, zero, neg
    );

endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier, one multiplier bit per cycle.
// Ports: clk, rst_n, start, a, b in; done (one cycle), prod (2*WIDTH) out.
module alu_mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] prod
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic               busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            // After WIDTH iterations the product sits in acc for one
            // cycle while done is high, then the unit goes idle.
            if (cnt == LAST) begin
                busy <= 1'b0;
            end else begin
                if (mplier[0]) begin
                    acc <= acc + mcand;
                end
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
            end
        end
    end

    assign done = busy && (cnt == LAST);
    assign prod = acc;

endmodule

// File: rtl/registered_alu.sv
// Registered ALU: single-cycle ops plus an iterative multiply, valid/ready.
// Ports: clk, rst_n, bus (registered_alu_if.slave: operands, opcode, result, flags).
module registered_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic clk,
    input  logic rst_n,
    registered_alu_if.slave bus
);

    localparam int MSB = WIDTH - 1;

    logic [1:0]         state;
    logic               accept;
    logic               is_mul;
    logic               mul_done;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   mul_lo;
    logic [WIDTH-1:0]   mul_hi;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [SHW-1:0]     sh;
    logic [WIDTH-1:0]   nz;
    logic               ncout;
    logic               novf;

    logic [WIDTH-1:0]   z_q;
    logic [WIDTH-1:0]   z_hi_q;
    logic               cout_q;
    logic               ovf_q;
    logic               zero_q;
    logic               neg_q;

    // A held result can be retired and replaced on the same edge.
    assign bus.in_ready  = (state == ST_IDLE) ||
                           ((state == ST_HOLD) && bus.out_ready);
    assign bus.out_valid = (state == ST_HOLD);
    assign accept        = bus.in_valid && bus.in_ready;
    assign is_mul        = (bus.F == OP_MUL);

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (accept && is_mul),
        .a     (bus.a),
        .b     (bus.b),
        .done  (mul_done),
        .prod  (prod)
    );

    assign mul_lo = prod[WIDTH-1:0];
    assign mul_hi = prod[2*WIDTH-1:WIDTH];

    always_comb begin
        sum   = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.cin};
        // Top bit of diff is the borrow out of a - b - cin.
        diff  = {1'b0, bus.a} - {1'b0, bus.b} - {{WIDTH{1'b0}}, bus.cin};
        sh    = bus.b[SHW-1:0];
        nz    = '0;
        ncout = 1'b0;
        novf  = 1'b0;
        unique case (bus.F)
            OP_ADD: begin
                nz    = sum[WIDTH-1:0];
                ncout = sum[WIDTH];
                novf  = (bus.a[MSB] == bus.b[MSB]) &&
                        (sum[MSB] != bus.a[MSB]);
            end
            OP_SUB: begin
                nz    = diff[WIDTH-1:0];
                ncout = ~diff[WIDTH];
                novf  = (bus.a[MSB] != bus.b[MSB]) &&
                        (diff[MSB] != bus.a[MSB]);
            end
            OP_AND:  nz = bus.a & bus.b;
            OP_OR:   nz = bus.a | bus.b;
            OP_XOR:  nz = bus.a ^ bus.b;
            OP_SHL:  nz = bus.a << sh;
            OP_SHR:  nz = bus.a >> sh;
            default: nz = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            z_q    <= '0;
            z_hi_q <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b1;
            neg_q  <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE, ST_HOLD: begin
                    if (accept) begin
                        if (is_mul) begin
                            state <= ST_MUL;
                        end else begin
                            z_q    <= nz;
                            z_hi_q <= '0;
                            cout_q <= ncout;
                            ovf_q  <= novf;
                            zero_q <= ~|nz;
                            neg_q  <= nz[MSB];
                            state  <= ST_HOLD;
                        end
                    end else if ((state == ST_HOLD) && bus.out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        z_q    <= mul_lo;
                        z_hi_q <= mul_hi;
                        cout_q <= 1'b0;
                        ovf_q  <= 1'b0;
                        zero_q <= ~|prod;
                        neg_q  <= mul_hi[MSB];
                        state  <= ST_HOLD;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.z    = z_q;
    assign bus.z_hi = z_hi_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
    assign bus.zero = zero_q;
    assign bus.neg  = neg_q;

endmodule

// File: doc/registered_alu.md
REGISTERED_ALU -- requirements
Module: registered_alu

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits, legal range 4..32.
REQ-002 Parameter SHW, default $clog2(WIDTH): number of low bits of b used as the shift amount.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 a, b  input  WIDTH  operands.
REQ-006 F  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 MUL (unsigned).
REQ-007 cin  input  1  carry-in for ADD, borrow-in for SUB; ignored by all other ops.
REQ-008 in_valid / in_ready  input / output  1  operation request handshake.
REQ-009 out_valid / out_ready  output / input  1  result handshake.
REQ-010 z  output  WIDTH  result, or the low half of the product for MUL.
REQ-011 z_hi  output  WIDTH  high half of the product for MUL; 0 for every other op.
REQ-012 cout, ovf, zero, neg  output  1 each  result flags.

Function
REQ-013 A request is accepted on a rising edge where in_valid && in_ready; a, b, F and cin are captured on that edge.
REQ-014 The FSM states are IDLE, MUL, and HOLD.
REQ-015 IDLE: an accepted non-MUL op loads z and the flags and goes to HOLD, so out_valid rises on the cycle after acceptance (latency 1).
REQ-016 IDLE: an accepted MUL loads the multiplicand and multiplier, clears the accumulator and counter, and goes to MUL.
REQ-017 MUL is an iterative shift-add of one multiplier bit per cycle, running WIDTH cycles.
REQ-018 MUL: after the last iteration the FSM loads z/z_hi and goes to HOLD, giving out_valid exactly WIDTH+1 cycles after acceptance.
REQ-019 HOLD: out_valid=1, and z, z_hi and the flags stay stable until out_valid && out_ready; that edge returns the FSM to IDLE.
REQ-020 in_ready=1 in IDLE, and in HOLD during a cycle where out_ready=1 (back-to-back, one result per cycle for non-MUL ops); in_ready=0 in MUL.
REQ-021 If a request is accepted in HOLD on the same edge the result is consumed, the new op follows the IDLE rules (HOLD->HOLD or HOLD->MUL).
REQ-022 ADD: {cout,z} = a + b + cin over WIDTH+1 bits; ovf=1 iff a and b have the same sign and z's sign differs from it.
REQ-023 SUB: z = a - b - cin mod 2^WIDTH; cout=1 iff a >= b + cin (no borrow); ovf=1 iff a and b signs differ and z's sign differs from a's.
REQ-024 AND/OR/XOR: bitwise on a and b.
REQ-025 SHL/SHR: a shifted by b[SHW-1:0], zero fill; shift 0 returns a unchanged.
REQ-026 MUL: {z_hi,z} = a*b over 2*WIDTH bits.
REQ-027 cout and ovf are 0 for every op other than ADD/SUB; the flags never retain values from a previous op.
REQ-028 zero=1 iff z==0 (and z_hi==0 for MUL); neg = z[WIDTH-1] (z_hi[WIDTH-1] for MUL).
REQ-029 Inputs arriving while in_ready=0 are ignored, with no effect on state.

Reset
REQ-030 On rst_n=0, immediately and regardless of clock: state=IDLE, out_valid=0, z=0, z_hi=0, cout=ovf=neg=0, zero=1, and the MUL counter/accumulator=0.
REQ-031 Reset asserted mid-MUL or in HOLD abandons the operation; no result is presented after release.
REQ-032 First acceptance is possible on the first rising edge with rst_n=1.

Structure
REQ-033 Package alu_pkg holds the opcode constants (OP_ADD..OP_MUL) and the FSM state encoding.
REQ-034 One sub-module, alu_mul_iter (the iterative shift-add multiplier with start/done), is instantiated once.
REQ-035 All other datapath logic is combinational in the top level, feeding the output registers.

Verification
REQ-036 WIDTH=8, ADD a=0x7F b=0x01 cin=0 -> z=0x80, ovf=1, cout=0, neg=1, out_valid one cycle after acceptance.
REQ-037 SUB a=0x00 b=0x01 cin=0 -> z=0xFF, cout=0, ovf=0; then AND after it -> cout=0, ovf=0 (no stale flags).
REQ-038 MUL a=0xFF b=0xFF -> {z_hi,z}=0xFE01, out_valid at acceptance+9 cycles, in_ready=0 throughout MUL.
REQ-039 out_ready held 0 for 5 cycles in HOLD -> z and flags stable, in_ready=0; then stream ADD,XOR,SHL with out_ready=1 -> one result per cycle.
REQ-040 rst_n pulsed low at MUL cycle 4 -> outputs at reset values at once, no out_valid afterwards; next ADD 3+4 -> z=7.
REQ-041 SHR a=0x80 b=0x0F (shift amount 7) -> z=0x01; the same bench rerun at WIDTH=16 passes a 10k-op random check against a reference model.
